fb_scale_reader: RTL and testbench

FB_SCALE_READER -- requirements
Module: fb_scale_reader

---
 rtl/fb_scale_reader_if.sv | 11 +
 rtl/fb_scale_reader.sv | 206 ++++++++++++++++++++
 tb/tb_fb_scale_reader.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_scale_reader_if.sv
// Frame buffer read port shared by the scaler (master) and the frame store (slave).
interface fb_scale_reader_if #(
    parameter int ADDR_W = 15,
    parameter int PIX_W  = 12
);
    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  rd_data;

    modport master (output rd_addr, input  rd_data);
    modport slave  (input  rd_addr, output rd_data);
endinterface

// File: rtl/fb_scale_reader.sv
// Upscaling frame buffer reader: maps the display coordinate onto a smaller
// stored frame, fetches the pixel and applies a per-frame display mode
// (pass-through, grayscale, colour bars, solid border) with aligned syncs.
module fb_scale_reader #(
    parameter int SRC_W      = 160,
    parameter int SRC_H      = 120,
    parameter int SCALE_LOG2 = 2,
    parameter int DISP_W     = 640,
    parameter int DISP_H     = 480,
    parameter int ADDR_W     = 15,
    parameter int PIX_W      = 12,
    parameter int RD_LAT     = 1
) (
    input  logic                 pixel_clk,
    input  logic                 reset_n,
    input  logic [9:0]           drawX,
    input  logic [9:0]           drawY,
    input  logic                 hs_in,
    input  logic                 vs_in,
    input  logic                 vde_in,
    input  logic [1:0]           mode,
    input  logic                 mirror,
    input  logic [PIX_W-1:0]     border_rgb,
    fb_scale_reader_if.master    fb,
    output logic [PIX_W/3-1:0]   red,
    output logic [PIX_W/3-1:0]   green,
    output logic [PIX_W/3-1:0]   blue,
    output logic                 hs_out,
    output logic                 vs_out,
    output logic                 vde_out,
    output logic [7:0]           frame_cnt
);
    localparam int L      = RD_LAT + 2;
    localparam int CW     = PIX_W / 3;
    localparam int SEG    = DISP_W / 8;
    localparam int SEG_CW = (SEG > 1) ? $clog2(SEG) : 1;
    localparam int CTL_W  = 7;  // {mode[1:0], bar[2:0], in_img, vde}
    localparam int SYN_W  = 3;  // {vde, vs, hs}

    // The whole stored frame must be addressable.
    generate
        if (SRC_W * SRC_H > (1 << ADDR_W)) begin : g_fb_size_check
            $error("fb_scale_reader: SRC_W*SRC_H exceeds 2**ADDR_W");
        end
        if (RD_LAT < 1 || RD_LAT > 3) begin : g_rd_lat_check
            $error("fb_scale_reader: RD_LAT must be 1..3");
        end
    endgenerate

    logic [1:0]              mode_r;
    logic                    mirror_r;
    logic [7:0]              frame_cnt_r;
    logic                    vde_prev_r;
    logic [SEG_CW-1:0]       cnt_r;
    logic [2:0]              bar_r;
    logic [ADDR_W-1:0]       rd_addr_r;
    logic [L-2:0][CTL_W-1:0] ctl_r;
    logic [L-1:0][SYN_W-1:0] syn_r;
    logic [CW-1:0]           red_r;
    logic [CW-1:0]           green_r;
    logic [CW-1:0]           blue_r;

    logic [9:0]              sx_s;
    logic [9:0]              sy_s;
    logic                    in_img_s;
    logic [31:0]             sxm_s;
    logic [31:0]             addr_full_s;
    logic                    vblank_start_s;
    logic [2:0]              cur_bar_s;
    logic [SEG_CW-1:0]       cur_cnt_s;
    logic [CTL_W-1:0]        ctl_out_s;
    logic [CW-1:0]           r_s;
    logic [CW-1:0]           g_s;
    logic [CW-1:0]           b_s;
    logic [CW+1:0]           luma_sum_s;
    logic [CW-1:0]           luma_s;
    logic [3*CW-1:0]         rgb_mode_s;
    logic [3*CW-1:0]         rgb_next_s;

    assign sx_s           = drawX >> SCALE_LOG2;
    assign sy_s           = drawY >> SCALE_LOG2;
    assign in_img_s       = (32'(sx_s) < 32'(SRC_W)) && (32'(sy_s) < 32'(SRC_H));
    assign vblank_start_s = (drawX == 10'd0) && (32'(drawY) == 32'(DISP_H));

    // Source address with optional horizontal mirror, computed at 32 bits.
    always_comb begin
        sxm_s = 32'(sx_s);
        if (mirror_r) begin
            sxm_s = 32'(SRC_W - 1) - 32'(sx_s);
        end else begin
            sxm_s = 32'(sx_s);
        end
        addr_full_s = 32'(sy_s) * 32'(SRC_W) + sxm_s;
    end

    // Bar index of the current pixel; a rising vde starts a new line at bar 0.
    always_comb begin
        cur_bar_s = bar_r;
        cur_cnt_s = cnt_r;
        if (vde_in && !vde_prev_r) begin
            cur_bar_s = 3'd0;
            cur_cnt_s = '0;
        end else begin
            cur_bar_s = bar_r;
            cur_cnt_s = cnt_r;
        end
    end

    // Bar counter: advance every DISP_W/8 active pixels, saturating at bar 7.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            vde_prev_r <= 1'b0;
            cnt_r      <= '0;
            bar_r      <= 3'd0;
        end else begin
            vde_prev_r <= vde_in;
            if (vde_in) begin
                if (cur_cnt_s == SEG_CW'(SEG - 1)) begin
                    cnt_r <= '0;
                    bar_r <= (cur_bar_s == 3'd7) ? 3'd7 : cur_bar_s + 3'd1;
                end else begin
                    cnt_r <= cur_cnt_s + SEG_CW'(1);
                    bar_r <= cur_bar_s;
                end
            end else begin
                cnt_r <= cnt_r;
                bar_r <= bar_r;
            end
        end
    end

    // Mode/mirror are taken only at the start of vertical blank, which also ends a frame.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_r      <= 2'd0;
            mirror_r    <= 1'b0;
            frame_cnt_r <= 8'd0;
        end else if (vblank_start_s) begin
            mode_r      <= mode;
            mirror_r    <= mirror;
            frame_cnt_r <= frame_cnt_r + 8'd1;
        end else begin
            mode_r      <= mode_r;
            mirror_r    <= mirror_r;
            frame_cnt_r <= frame_cnt_r;
        end
    end

    // Address register plus control/sync delay lines matched to the read latency.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr_r <= '0;
            ctl_r     <= '0;
            syn_r     <= '0;
        end else begin
            rd_addr_r <= in_img_s ? ADDR_W'(addr_full_s) : '0;
            ctl_r     <= {ctl_r[L-3:0], {mode_r, cur_bar_s, in_img_s, vde_in}};
            syn_r     <= {syn_r[L-2:0], {vde_in, vs_in, hs_in}};
        end
    end

    // Colour selection for the pixel whose read data is arriving now.
    always_comb begin
        ctl_out_s  = ctl_r[L-2];
        r_s        = fb.rd_data[3*CW-1 -: CW];
        g_s        = fb.rd_data[2*CW-1 -: CW];
        b_s        = fb.rd_data[CW-1:0];
        luma_sum_s = {2'b00, r_s} + {1'b0, g_s, 1'b0} + {2'b00, b_s};
        luma_s     = CW'(luma_sum_s >> 2);
        rgb_mode_s = '0;
        case (ctl_out_s[6:5])
            2'd0: rgb_mode_s = ctl_out_s[1] ? fb.rd_data[3*CW-1:0] : border_rgb[3*CW-1:0];
            2'd1: rgb_mode_s = ctl_out_s[1] ? {luma_s, luma_s, luma_s} : border_rgb[3*CW-1:0];
            2'd2: rgb_mode_s = {{CW{ctl_out_s[4]}}, {CW{ctl_out_s[3]}}, {CW{ctl_out_s[2]}}};
            2'd3: rgb_mode_s = border_rgb[3*CW-1:0];
            default: rgb_mode_s = '0;
        endcase
        if (ctl_out_s[0]) begin
            rgb_next_s = rgb_mode_s;
        end else begin
            rgb_next_s = '0;
        end
    end

    // Registered colour outputs, blanked outside active video.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            red_r   <= '0;
            green_r <= '0;
            blue_r  <= '0;
        end else begin
            red_r   <= rgb_next_s[3*CW-1 -: CW];
            green_r <= rgb_next_s[2*CW-1 -: CW];
            blue_r  <= rgb_next_s[CW-1:0];
        end
    end

    assign fb.rd_addr = rd_addr_r;
    assign red        = red_r;
    assign green      = green_r;
    assign blue       = blue_r;
    assign hs_out     = syn_r[L-1][0];
    assign vs_out     = syn_r[L-1][1];
    assign vde_out    = syn_r[L-1][2];
    assign frame_cnt  = frame_cnt_r;
endmodule

// File: tb/tb_fb_scale_reader.sv
// Scoreboard bench for fb_scale_reader: a default instance and a SRC_W=100
// instance share the timing stimulus; expectations come from a bench model.
module tb_fb_scale_reader;
    localparam int RD_LAT = 1;
    localparam int L      = RD_LAT + 2;

    typedef struct packed {
        logic [14:0] a;
        logic [14:0] b;
    } ent_t;

    logic        pixel_clk;
    logic        reset_n;
    logic [9:0]  drawX, drawY;
    logic        hs_in, vs_in, vde_in;
    logic [1:0]  mode_in;
    logic        mirror_in;
    logic [11:0] border_rgb;
    logic [3:0]  red, green, blue, red100, green100, blue100;
    logic        hs_out, vs_out, vde_out, hs100, vs100, vde100;
    logic [7:0]  frame_cnt, frame_cnt100;

    logic [11:0] mem [0:32767];
    logic [11:0] rd_dly [RD_LAT];

    int          n_total;
    int          n_bad;
    ent_t        sb_q[$];
    logic [1:0]  mode_m;
    logic        mirror_m;
    logic [7:0]  fcnt_m;
    logic        vprev_m;
    int          seen_m;
    int          exp_addr_a;
    int          exp_addr_b;

    fb_scale_reader_if #(.ADDR_W(15), .PIX_W(12)) fb_if ();
    fb_scale_reader_if #(.ADDR_W(15), .PIX_W(12)) fb100 ();

    fb_scale_reader #(.RD_LAT(RD_LAT)) u_dut (
        .pixel_clk(pixel_clk), .reset_n(reset_n), .drawX(drawX), .drawY(drawY),
        .hs_in(hs_in), .vs_in(vs_in), .vde_in(vde_in), .mode(mode_in), .mirror(mirror_in),
        .border_rgb(border_rgb), .fb(fb_if), .red(red), .green(green), .blue(blue),
        .hs_out(hs_out), .vs_out(vs_out), .vde_out(vde_out), .frame_cnt(frame_cnt)
    );

    fb_scale_reader #(.SRC_W(100), .RD_LAT(RD_LAT)) u_dut100 (
        .pixel_clk(pixel_clk), .reset_n(reset_n), .drawX(drawX), .drawY(drawY),
        .hs_in(hs_in), .vs_in(vs_in), .vde_in(vde_in), .mode(mode_in), .mirror(mirror_in),
        .border_rgb(border_rgb), .fb(fb100), .red(red100), .green(green100), .blue(blue100),
        .hs_out(hs100), .vs_out(vs100), .vde_out(vde100), .frame_cnt(frame_cnt100)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    // Frame store model: data appears RD_LAT cycles after the address.
    always @(posedge pixel_clk) begin
        rd_dly[0] <= mem[fb_if.rd_addr];
        for (int i = 1; i < RD_LAT; i++) rd_dly[i] <= rd_dly[i-1];
    end
    assign fb_if.rd_data = rd_dly[RD_LAT-1];
    assign fb100.rd_data = 12'h123;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_in(input int x, input int y, input int srcw);
        return (((x % 1024) >> 2) < srcw) && (((y % 1024) >> 2) < 120);
    endfunction

    function automatic int model_addr(input int x, input int y, input logic mir, input int srcw);
        int sx, sy;
        sx = (x % 1024) >> 2;
        sy = (y % 1024) >> 2;
        if (!model_in(x, y, srcw)) return 0;
        if (mir) sx = srcw - 1 - sx;
        return sy * srcw + sx;
    endfunction

    function automatic logic [11:0] exp_rgb(input logic [1:0] md, input logic de, input logic inimg,
                                            input logic [11:0] d, input logic [2:0] bar);
        int yv;
        logic [3:0] y4;
        exp_rgb = 12'h000;
        if (de) begin
            case (md)
                2'd0: exp_rgb = inimg ? d : border_rgb;
                2'd1: begin
                    yv = (int'(d[11:8]) + 2 * int'(d[7:4]) + int'(d[3:0])) / 4;
                    y4 = 4'(yv);
                    exp_rgb = inimg ? {y4, y4, y4} : border_rgb;
                end
                2'd2: exp_rgb = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
                default: exp_rgb = border_rgb;
            endcase
        end
    endfunction

    // One pixel clock: check what the DUTs show now, drive the next input, record its expectation.
    task automatic step(input int x, input int y, input logic h, input logic v, input logic de);
        ent_t e;
        int   idx, bar, aa, ab;
        logic ia, ib;
        chk_val("rd_addr", 32'(fb_if.rd_addr), 32'(exp_addr_a));
        chk_val("rd_addr100", 32'(fb100.rd_addr), 32'(exp_addr_b));
        chk_val("frame_cnt", 32'(frame_cnt), 32'(fcnt_m));
        if (sb_q.size() >= L) begin
            e = sb_q.pop_front();
            chk_val("out", 32'({red, green, blue, hs_out, vs_out, vde_out}), 32'(e.a));
            chk_val("out100", 32'({red100, green100, blue100, hs100, vs100, vde100}), 32'(e.b));
        end
        drawX = 10'(x); drawY = 10'(y); hs_in = h; vs_in = v; vde_in = de;
        idx = (de && !vprev_m) ? 0 : seen_m;
        if (de) seen_m = idx + 1;
        vprev_m = de;
        bar = (idx / 80 > 7) ? 7 : idx / 80;
        ia = model_in(x, y, 160);
        ib = model_in(x, y, 100);
        aa = model_addr(x, y, mirror_m, 160);
        ab = model_addr(x, y, mirror_m, 100);
        e.a = {exp_rgb(mode_m, de, ia, mem[aa], 3'(bar)), h, v, de};
        e.b = {exp_rgb(mode_m, de, ib, 12'h123, 3'(bar)), h, v, de};
        exp_addr_a = aa;
        exp_addr_b = ab;
        if ((x % 1024) == 0 && (y % 1024) == 480) begin
            mode_m   = mode_in;
            mirror_m = mirror_in;
            fcnt_m   = fcnt_m + 8'd1;
        end
        sb_q.push_back(e);
        @(negedge pixel_clk);
    endtask

    task automatic run_line(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) step(x, y, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic blank(input int n, input int y);
        for (int i = 0; i < n; i++) step(640 + i, y, (i < 4) ? 1'b1 : 1'b0, 1'b0, 1'b0);
    endtask

    task automatic vb_latch();
        step(0, 480, 1'b0, 1'b1, 1'b0);
        blank(4, 480);
    endtask

    // Asynchronous reset between clock edges; pipeline starts as L-1 cleared entries.
    task automatic do_reset();
        @(posedge pixel_clk);
        #2 reset_n = 1'b0;
        #1;
        chk_val("rst_rd_addr", 32'(fb_if.rd_addr), 32'd0);
        chk_val("rst_rgb", 32'({red, green, blue}), 32'd0);
        chk_val("rst_sync", 32'({hs_out, vs_out, vde_out}), 32'd0);
        chk_val("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        sb_q.delete();
        mode_m = 2'd0; mirror_m = 1'b0; fcnt_m = 8'd0; vprev_m = 1'b0; seen_m = 0;
        exp_addr_a = 0; exp_addr_b = 0;
        for (int i = 0; i < L - 1; i++) sb_q.push_back('0);
        @(negedge pixel_clk);
        reset_n = 1'b1;
    endtask

    initial begin
        n_total = 0; n_bad = 0;
        reset_n = 1'b0;
        drawX = 10'd0; drawY = 10'd0; hs_in = 1'b0; vs_in = 1'b0; vde_in = 1'b0;
        mode_in = 2'd0; mirror_in = 1'b0; border_rgb = 12'h5A3;
        for (int i = 0; i < 32768; i++) mem[i] = 12'($urandom);
        mem[162] = 12'hABC;
        mem[320] = 12'h4C8;
        do_reset();
        blank(4, 0);
        vb_latch();

        // Mode 0: address and pass-through data.
        run_line(4, 0, 7);
        step(8, 4, 1'b0, 1'b0, 1'b1);
        chk_val("addr_8_4", 32'(fb_if.rd_addr), 32'd162);
        run_line(4, 9, 8 + L - 1);
        chk_val("rgb_abc", 32'({red, green, blue}), 32'h0ABC);
        run_line(4, 8 + L, 399);
        step(400, 4, 1'b0, 1'b0, 1'b1);
        chk_val("addr100_x400", 32'(fb100.rd_addr), 32'd0);
        run_line(4, 401, 400 + L - 1);
        chk_val("rgb100_x400", 32'({red100, green100, blue100}), 32'(border_rgb));
        run_line(4, 400 + L, 639);
        blank(8, 4);
        step(1023, 1023, 1'b0, 1'b0, 1'b0);
        chk_val("addr_far", 32'(fb_if.rd_addr), 32'd0);
        blank(4, 4);

        // Mode 1: grayscale, then blanking forces black.
        mode_in = 2'd1;
        vb_latch();
        run_line(8, 0, L - 1);
        chk_val("rgb_luma", 32'({red, green, blue}), 32'h0999);
        run_line(8, L, 639);
        blank(L, 8);
        chk_val("rgb_vde0", 32'({red, green, blue}), 32'd0);
        blank(4, 8);

        // Mode 2: colour bars.
        mode_in = 2'd2;
        vb_latch();
        run_line(0, 0, L - 1);
        chk_val("bar_first", 32'({red, green, blue}), 32'h0000);
        run_line(0, L, 639);
        blank(L - 1, 0);
        chk_val("bar_last", 32'({red, green, blue}), 32'h0FFF);
        blank(6, 0);

        // Mirror.
        mode_in = 2'd0; mirror_in = 1'b1;
        vb_latch();
        step(0, 0, 1'b0, 1'b0, 1'b1);
        chk_val("mirror_x0", 32'(fb_if.rd_addr), 32'd159);
        run_line(0, 1, 635);
        step(636, 0, 1'b0, 1'b0, 1'b1);
        chk_val("mirror_x636", 32'(fb_if.rd_addr), 32'd0);
        run_line(0, 637, 639);
        blank(8, 0);

        // Mode request mid-frame must wait for vertical blank.
        run_line(4, 0, 319);
        mode_in = 2'd3;
        run_line(4, 320, 639);
        blank(8, 4);
        vb_latch();
        run_line(4, 0, L - 1);
        chk_val("border_mode3", 32'({red, green, blue}), 32'(border_rgb));
        run_line(4, L, 639);
        blank(8, 4);

        // Frame counter wrap.
        while (fcnt_m != 8'd255) step(0, 480, 1'b0, 1'b1, 1'b0);
        step(0, 480, 1'b0, 1'b1, 1'b0);
        chk_val("fcnt_wrap", 32'(frame_cnt), 32'd0);
        blank(4, 480);

        // Reset in the middle of a line.
        mode_in = 2'd0; mirror_in = 1'b0;
        vb_latch();
        run_line(4, 0, 100);
        do_reset();
        step(101, 4, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < L - 2; i++) step(102 + i, 4, 1'b0, 1'b0, 1'b1);
        chk_val("hs_not_yet", 32'(hs_out), 32'd0);
        step(100 + L, 4, 1'b0, 1'b0, 1'b1);
        chk_val("hs_after_L", 32'(hs_out), 32'd1);
        run_line(4, 101 + L, 639);
        blank(L + 4, 4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
